// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave.
//   DATA_W_DEF           default transfer word width
//   spi_state_t          slave FSM states
//   SS_RST/SCK_RST/MOSI_RST  reset values of the synchronized pin copies
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

    // The pins reset to their idle levels so no edge is seen coming out of reset.
    localparam logic SS_RST   = 1'b1;
    localparam logic SCK_RST  = 1'b0;
    localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a previous-value register for
// edge detection.
//   clk, rst  system clock, synchronous active-high reset
//   din       asynchronous pin input
//   level     synchronized level
//   rise      one-cycle pulse on a synchronized 0->1 transition
//   fall      one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled in the clk domain.
//   clk, rst     system clock, synchronous active-high reset
//   sck, ss      SPI clock (idle low) and active-low select from the master
//   mosi, miso   serial data in / out (miso is 0 while not selected)
//   tx_data, tx_load, tx_ready   one-entry transmit buffer write port
//   rx_data, rx_valid            last received word and its one-cycle strobe
//   busy         transfer in progress
//   tx_underrun  sticky: a word started with the transmit buffer empty
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int unsigned     CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_sync_edge #(
        .RST_VAL (SCK_RST)
    ) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(
        .RST_VAL (SS_RST)
    ) u_sync_ss (
        .clk   (clk),
        .rst   (rst),
        .din   (ss),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // mosi only needs its synchronized level; it is stable around sck edges.
    logic mosi_s1_q, mosi_s1_d;
    logic mosi_s2_q, mosi_s2_d;

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;   // a word has completed in this selection

    logic              consume;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_next;

    always_comb begin
        mosi_s1_d  = mosi;
        mosi_s2_d  = mosi_s1_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        miso_d     = miso_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        underrun_d = underrun_q;
        done_d     = done_q;
        consume    = 1'b0;
        tx_shift   = tx_sr_q << 1;
        rx_next    = {rx_sr_q[DATA_W-2:0], mosi_s2_q};

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    consume = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    // Deselect wins; a partial receive word is dropped silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    miso_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_sr_d = rx_next;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    if (cnt_q == '0 && done_q) begin
                        consume = 1'b1;
                    end else begin
                        tx_sr_d = tx_shift;
                        miso_d  = tx_shift[DATA_W-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            tx_sr_d    = buf_full_q ? buf_q : '0;
            miso_d     = buf_full_q ? buf_q[DATA_W-1] : 1'b0;
            underrun_d = underrun_q | ~buf_full_q;
            buf_full_d = 1'b0;
        end

        // Evaluated after the consume so a same-cycle load leaves the buffer full.
        if (tx_load && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1_q  <= MOSI_RST;
            mosi_s2_q  <= MOSI_RST;
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q == ACTIVE);
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives random words; a transaction-level
// model of the transmit buffer predicts miso words and underrun, and expected receive
// words go into a queue that a separate monitor drains on every rx_valid.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       miso;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;

    int checks = 0;
    int failures = 0;

    spi_slave #(
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_buf = 8'h00;
    bit         m_full = 1'b0;
    bit         m_underrun = 1'b0;
    logic [7:0] m_last_rx = 8'h00;
    logic [7:0] exp_q[$];

    // Per-transaction stimulus
    logic [7:0] xm_mosi[4];
    bit         xm_ld[4];
    logic [7:0] xm_ldv[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_consume();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        m_underrun = 1'b1;
        return 8'h00;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        chk("tx_ready_before_load", {31'd0, tx_ready}, {31'd0, !m_full});
        tx_data = v;
        tx_load = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Mode-0 master; the final sck fall coincides with the ss rise.
    task automatic xfer(input int nbits);
        logic [7:0] txw;
        @(negedge clk);
        ss  = 1'b0;
        txw = m_consume();
        wait_clk(6);
        chk("busy_after_select", {31'd0, busy}, 32'd1);
        chk("underrun_after_select", {31'd0, tx_underrun}, {31'd0, m_underrun});
        for (int b = 0; b < nbits; b++) begin
            automatic int w = b / 8;
            automatic int k = b % 8;
            mosi = xm_mosi[w][7-k];
            wait_clk(4);
            chk("miso_bit", {31'd0, miso}, {31'd0, txw[7-k]});
            sck = 1'b1;
            if (k == 7) begin
                exp_q.push_back(xm_mosi[w]);
                m_last_rx = xm_mosi[w];
            end
            if (k == 3 && xm_ld[w]) begin
                wait_clk(1);
                do_load(xm_ldv[w]);
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
            if (b == nbits - 1) break;
            sck = 1'b0;
            if (k == 7) txw = m_consume();
        end
        ss   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        wait_clk(6);
        chk("busy_after_deselect", {31'd0, busy}, 32'd0);
        chk("miso_after_deselect", {31'd0, miso}, 32'd0);
        chk("underrun_end", {31'd0, tx_underrun}, {31'd0, m_underrun});
        chk("tx_ready_end", {31'd0, tx_ready}, {31'd0, !m_full});
        chk("rx_data_held", {24'd0, rx_data}, {24'd0, m_last_rx});
        chk("rx_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) xm_ld[i] = 1'b0;
    endtask

    // Monitor: every rx_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, expected none at %0t",
                         rx_data, $time);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            xm_mosi[i] = 8'h00;
            xm_ld[i]   = 1'b0;
            xm_ldv[i]  = 8'h00;
        end
        wait_clk(3);
        check_reset_values();
        rst = 1'b0;
        wait_clk(2);

        // Single byte
        do_load(8'hA5);
        xm_mosi[0] = 8'hAF;
        xfer(8);

        // Back-to-back with a reload during byte 1
        do_load(8'h3C);
        xm_mosi[0] = 8'($urandom);
        xm_mosi[1] = 8'($urandom);
        xm_ld[0]   = 1'b1;
        xm_ldv[0]  = 8'hC3;
        xfer(16);
        chk("b2b_no_underrun", {31'd0, tx_underrun}, 32'd0);

        // Underrun: no load
        xm_mosi[0] = 8'($urandom);
        xfer(8);
        chk("underrun_set", {31'd0, tx_underrun}, 32'd1);

        // Abort after 5 rises, then a fresh full byte
        do_load(8'($urandom));
        xm_mosi[0] = 8'($urandom);
        xfer(5);
        do_load(8'($urandom));
        xm_mosi[0] = 8'($urandom);
        xfer(8);

        // Load while full is ignored
        do_load(8'h11);
        do_load(8'h22);
        xm_mosi[0] = 8'($urandom);
        xfer(8);

        // Mid-transfer reset during bit 3
        do_load(8'h5A);
        @(negedge clk);
        ss = 1'b0;
        wait_clk(6);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'($urandom);
            wait_clk(4);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
        wait_clk(1);
        rst = 1'b1;
        wait_clk(1);
        check_reset_values();
        rst  = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        m_full     = 1'b0;
        m_underrun = 1'b0;
        m_last_rx  = 8'h00;
        exp_q.delete();
        wait_clk(6);
        chk("post_rst_buffer_empty", {31'd0, tx_ready}, 32'd1);
        xm_mosi[0] = 8'($urandom);
        xfer(8);

        // Random transactions
        for (int t = 0; t < 20; t++) begin
            automatic int nw = int'($urandom_range(1, 3));
            automatic int nb = nw * 8;
            if ($urandom_range(0, 4) == 0) nb = nb - int'($urandom_range(1, 7));
            if ($urandom_range(0, 3) != 0) do_load(8'($urandom));
            for (int i = 0; i < 4; i++) begin
                xm_mosi[i] = 8'($urandom);
                xm_ld[i]   = ($urandom_range(0, 2) != 0);
                xm_ldv[i]  = 8'($urandom);
            end
            xfer(nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
